turing_machine_multi: RTL and testbench

- Parametrised successor to the single-bit Turing machine.
- Multi-bit tape alphabet, configurable state count and tape length, and a programmable transition table loaded over a valid/ready port.
- Tape preload, single-step and free-run execution, step counting, and off-tape fault detection.
- Sits between the board I/O debouncers (step/run/load strobes) and the LED display driver.

---
 rtl/turing_machine_multi.sv | 190 +++++++++++++++++++
 tb/tb_turing_machine_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/turing_machine_multi.sv
// turing_machine_multi
//   Parametrised multi-symbol Turing machine. A transition table is loaded
//   first, then the tape, over one valid/ready port. After loading, the
//   machine runs one transition per rising edge of step, or free-runs at one
//   transition per RUN_DIV cycles while run_en is high. It stops when the
//   halt state is reached or when the head tries to leave the tape.
//
// Ports
//   clock        system clock
//   reset        synchronous, active low
//   prog_data    table entry {next_state, move(1=right), write_sym}; during
//                tape load, the low SYM_W bits are the symbol
//   prog_valid   prog_data valid
//   prog_ready   a word is accepted this cycle (high only while loading)
//   prog_last    with prog_valid during tape load: last tape symbol
//   step         level; each rising edge requests one transition
//   run_en       level; free-run while high
//   display_out  2*WIN+1 cells around the head; MSB group is the leftmost cell
//   curr_state   current machine state
//   step_count   transitions executed, saturating
//   halted       halt state reached
//   fault        head tried to leave the tape
//   phase        controller phase (0 load table .. 5 stop)
module turing_machine_multi #(
    parameter  int NUM_STATES = 8,
    parameter  int SYM_W      = 2,
    parameter  int TAPE_LEN   = 64,
    parameter  int WIN        = 5,
    parameter  int RUN_DIV    = 4,
    // Left overridable so narrow counters can be built; 16 is the normal width.
    parameter  int CNT_W      = 16,
    localparam int ST_W       = $clog2(NUM_STATES),
    localparam int ENTRY_W    = ST_W + 1 + SYM_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [ENTRY_W-1:0]           prog_data,
    input  logic                         prog_valid,
    output logic                         prog_ready,
    input  logic                         prog_last,
    input  logic                         step,
    input  logic                         run_en,
    output logic [(2*WIN+1)*SYM_W-1:0]   display_out,
    output logic [ST_W-1:0]              curr_state,
    output logic [CNT_W-1:0]             step_count,
    output logic                         halted,
    output logic                         fault,
    output logic [2:0]                   phase
);

    localparam int HEAD_W = $clog2(TAPE_LEN);
    localparam int ADDR_W = ST_W + SYM_W;
    localparam int DEPTH  = NUM_STATES << SYM_W;
    localparam int DIV_W  = $clog2(RUN_DIV + 1);
    localparam int CELLS  = 2 * WIN + 1;

    localparam logic [ST_W-1:0]   HALT_ST   = ST_W'(NUM_STATES - 1);
    localparam logic [HEAD_W-1:0] HEAD_HOME = HEAD_W'(TAPE_LEN / 2);
    localparam logic [HEAD_W-1:0] HEAD_MAX  = HEAD_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);

    typedef enum logic [2:0] {
        LOAD_TABLE = 3'd0,
        LOAD_TAPE  = 3'd1,
        READY      = 3'd2,
        FETCH      = 3'd3,
        EXEC       = 3'd4,
        STOP       = 3'd5
    } phase_t;

    typedef struct packed {
        logic [ST_W-1:0]  next_state;
        logic             move;
        logic [SYM_W-1:0] wsym;
    } entry_t;

    entry_t                         tbl [DEPTH];
    logic [TAPE_LEN-1:0][SYM_W-1:0] tape;
    logic [HEAD_W-1:0]              head;
    logic [HEAD_W-1:0]              load_ptr;
    logic [ADDR_W-1:0]              tbl_addr;
    entry_t                         entry;
    logic [DIV_W-1:0]               div_cnt;
    logic                           step_q;
    phase_t                         state_q;
    logic [CELLS-1:0][SYM_W-1:0]    win_next;
    logic [ST_W-1:0]                ns;
    logic                           step_edge;
    logic                           off_tape;

    assign prog_ready = (state_q == LOAD_TABLE) || (state_q == LOAD_TAPE);
    assign phase      = state_q;
    assign step_edge  = step & ~step_q;

    // Out-of-range next states are treated as the halt state.
    assign ns = (int'(entry.next_state) >= NUM_STATES) ? HALT_ST : entry.next_state;
    assign off_tape = entry.move ? (head == HEAD_MAX) : (head == '0);

    // Window around the head; group g shows cell head+WIN-g so the MSB group
    // is the leftmost cell. Cells off either end of the tape show blank.
    always_comb begin
        int c;
        c        = 0;
        win_next = '0;
        for (int g = 0; g < CELLS; g++) begin
            c = int'(head) + WIN - g;
            if (c >= 0 && c < TAPE_LEN) win_next[g] = tape[c[HEAD_W-1:0]];
        end
    end

    // Table storage has no reset: it is always reloaded after reset.
    always_ff @(posedge clock) begin
        if (reset && state_q == LOAD_TABLE && prog_valid)
            tbl[tbl_addr] <= entry_t'(prog_data);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= LOAD_TABLE;
            tbl_addr    <= '0;
            load_ptr    <= HEAD_HOME;
            tape        <= '0;
            head        <= HEAD_HOME;
            curr_state  <= '0;
            step_count  <= '0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            display_out <= '0;
            entry       <= '0;
            div_cnt     <= DIV_LAST;
            step_q      <= 1'b0;
        end else begin
            step_q      <= step;
            display_out <= win_next;
            // Free-running spacing counter: restarts at each FETCH and
            // saturates, so a fresh run starts without waiting.
            if (div_cnt != DIV_LAST) div_cnt <= div_cnt + 1'b1;

            case (state_q)
                LOAD_TABLE: begin
                    if (prog_valid) begin
                        tbl_addr <= tbl_addr + 1'b1;
                        if (tbl_addr == ADDR_LAST) state_q <= LOAD_TAPE;
                    end
                end
                LOAD_TAPE: begin
                    if (prog_valid) begin
                        tape[load_ptr] <= prog_data[SYM_W-1:0];
                        load_ptr       <= load_ptr + 1'b1;
                        if (prog_last || load_ptr == HEAD_MAX) state_q <= READY;
                    end
                end
                READY: begin
                    // run_en owns the machine; a coincident step edge is ignored.
                    if (run_en) begin
                        if (div_cnt == DIV_LAST) state_q <= FETCH;
                    end else if (step_edge) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    entry   <= tbl[{curr_state, tape[head]}];
                    div_cnt <= DIV_W'(1);
                    state_q <= EXEC;
                end
                EXEC: begin
                    tape[head] <= entry.wsym;
                    curr_state <= ns;
                    if (step_count != '1) step_count <= step_count + 1'b1;
                    if (off_tape) begin
                        fault   <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        head <= entry.move ? head + 1'b1 : head - 1'b1;
                        if (ns == HALT_ST) begin
                            halted  <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            state_q <= READY;
                        end
                    end
                end
                STOP:    ;
                default: state_q <= STOP;
            endcase
        end
    end

endmodule

// File: tb/tb_turing_machine_multi.sv
// Directed bench for turing_machine_multi. A second instance with a 4-bit
// step counter shares all inputs so counter saturation is reachable quickly.
module tb_turing_machine_multi;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  prog_data = '0;
    logic        prog_valid = 1'b0;
    logic        prog_last = 1'b0;
    logic        step = 1'b0;
    logic        run_en = 1'b0;

    logic        prog_ready;
    logic [21:0] display_out;
    logic [2:0]  curr_state;
    logic [15:0] step_count;
    logic        halted;
    logic        fault;
    logic [2:0]  phase;

    logic        sat_ready;
    logic [21:0] sat_disp;
    logic [2:0]  sat_state;
    logic [3:0]  sat_count;
    logic        sat_halted;
    logic        sat_fault;
    logic [2:0]  sat_phase;

    int n_cmp = 0;
    int n_bad = 0;

    turing_machine_multi dut (
        .clock(clock), .reset(reset), .prog_data(prog_data), .prog_valid(prog_valid),
        .prog_ready(prog_ready), .prog_last(prog_last), .step(step), .run_en(run_en),
        .display_out(display_out), .curr_state(curr_state), .step_count(step_count),
        .halted(halted), .fault(fault), .phase(phase)
    );

    turing_machine_multi #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .prog_data(prog_data), .prog_valid(prog_valid),
        .prog_ready(sat_ready), .prog_last(prog_last), .step(step), .run_en(run_en),
        .display_out(sat_disp), .curr_state(sat_state), .step_count(sat_count),
        .halted(sat_halted), .fault(sat_fault), .phase(sat_phase)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Stimulus: one word presented for one cycle (prog_ready is high while loading).
    task automatic send(input logic [5:0] d, input logic last);
        prog_data  = d;
        prog_last  = last;
        prog_valid = 1'b1;
        @(negedge clock);
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        prog_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0; prog_valid = 1'b0; step = 1'b0; run_en = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Table "always move left, stay in state 0, write 2"; tape is a single blank.
    task automatic load_left_table();
        for (int a = 0; a < 32; a++) send(6'h02, 1'b0);
        send(6'h00, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (phase !== 3'd0) begin n_bad++; $display("FAIL rst_phase: got %0d want 0", phase); end
        n_cmp++; if (prog_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", prog_ready); end
        n_cmp++; if (display_out !== 22'h0) begin n_bad++; $display("FAIL rst_disp: got %0h want 0", display_out); end
        n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", step_count); end
        n_cmp++; if ({halted, fault} !== 2'b00) begin n_bad++; $display("FAIL rst_flags: got %b want 00", {halted, fault}); end
        n_cmp++; if (curr_state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", curr_state); end
    endtask

    // Table: sym 0 -> write 1, move right, state 0; any other sym -> write 1,
    // move right, halt. prog_last is held high during the table and must be ignored.
    task automatic test_load();
        for (int a = 0; a < 31; a++) send((a % 4 == 0) ? 6'h05 : 6'h3D, 1'b1);
        n_cmp++; if (phase !== 3'd0) begin n_bad++; $display("FAIL tbl_phase31: got %0d want 0", phase); end
        send(6'h3D, 1'b1);
        n_cmp++; if (phase !== 3'd1) begin n_bad++; $display("FAIL tbl_done: got %0d want 1", phase); end
        step = 1'b1;                         // edge while loading must be dropped
        send(6'h00, 1'b0);
        send(6'h00, 1'b0);
        send(6'h01, 1'b1);
        n_cmp++; if (phase !== 3'd2) begin n_bad++; $display("FAIL tape_phase: got %0d want 2", phase); end
        n_cmp++; if (prog_ready !== 1'b0) begin n_bad++; $display("FAIL tape_ready: got %0b want 0", prog_ready); end
        @(negedge clock);
        n_cmp++; if (display_out !== 22'h000040) begin n_bad++; $display("FAIL tape_disp: got %0h want 40", display_out); end
        n_cmp++; if (display_out[11:10] !== 2'd0) begin n_bad++; $display("FAIL tape_centre: got %0d want 0", display_out[11:10]); end
        step = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL load_step_drop: got %0d want 0", step_count); end
    endtask

    task automatic test_single_step();
        step = 1'b1;
        @(negedge clock);
        n_cmp++; if (phase !== 3'd3) begin n_bad++; $display("FAIL s1_fetch: got %0d want 3", phase); end
        @(negedge clock);
        n_cmp++; if (phase !== 3'd4) begin n_bad++; $display("FAIL s1_exec: got %0d want 4", phase); end
        n_cmp++; if (step_count !== 16'd0) begin n_bad++; $display("FAIL s1_early: got %0d want 0", step_count); end
        @(negedge clock);
        n_cmp++; if (step_count !== 16'd1) begin n_bad++; $display("FAIL s1_count: got %0d want 1", step_count); end
        n_cmp++; if (phase !== 3'd2) begin n_bad++; $display("FAIL s1_ready: got %0d want 2", phase); end
        step = 1'b0;
        @(negedge clock);
        n_cmp++; if (display_out !== 22'h001100) begin n_bad++; $display("FAIL s1_disp: got %0h want 1100", display_out); end
        repeat (3) @(negedge clock);
    endtask

    // Second step; a new rising edge lands while the block is in EXEC.
    task automatic test_step_drop();
        step = 1'b1;
        @(negedge clock);
        step = 1'b0;
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        n_cmp++; if (step_count !== 16'd2) begin n_bad++; $display("FAIL s2_count: got %0d want 2", step_count); end
        repeat (5) @(negedge clock);
        n_cmp++; if (step_count !== 16'd2) begin n_bad++; $display("FAIL drop_count: got %0d want 2", step_count); end
        n_cmp++; if (phase !== 3'd2) begin n_bad++; $display("FAIL drop_phase: got %0d want 2", phase); end
        step = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_halt();
        step = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (step_count !== 16'd3) begin n_bad++; $display("FAIL s3_count: got %0d want 3", step_count); end
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL s3_halted: got %0b want 1", halted); end
        n_cmp++; if (phase !== 3'd5) begin n_bad++; $display("FAIL s3_phase: got %0d want 5", phase); end
        n_cmp++; if (curr_state !== 3'd7) begin n_bad++; $display("FAIL s3_state: got %0d want 7", curr_state); end
        step = 1'b0;
        @(negedge clock);
        n_cmp++; if (display_out !== 22'h015000) begin n_bad++; $display("FAIL s3_disp: got %0h want 15000", display_out); end
        step = 1'b1; run_en = 1'b1;
        repeat (10) @(negedge clock);
        n_cmp++; if (step_count !== 16'd3 || phase !== 3'd5) begin
            n_bad++; $display("FAIL stop_hold: got count %0d phase %0d want 3 5", step_count, phase);
        end
        step = 1'b0; run_en = 1'b0;
    endtask

    task automatic test_run_fault();
        do_reset();
        load_left_table();
        n_cmp++; if (phase !== 3'd2) begin n_bad++; $display("FAIL run_ready: got %0d want 2", phase); end
        run_en = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++; if (step_count !== 16'd1) begin n_bad++; $display("FAIL run_c1: got %0d want 1", step_count); end
        repeat (3) @(negedge clock);
        n_cmp++; if (step_count !== 16'd1) begin n_bad++; $display("FAIL run_hold: got %0d want 1", step_count); end
        @(negedge clock);
        n_cmp++; if (step_count !== 16'd2) begin n_bad++; $display("FAIL run_c2: got %0d want 2", step_count); end
        repeat (4) @(negedge clock);
        n_cmp++; if (step_count !== 16'd3) begin n_bad++; $display("FAIL run_c3: got %0d want 3", step_count); end
        for (int i = 0; i < 400 && phase !== 3'd5; i++) @(negedge clock);
        n_cmp++; if (phase !== 3'd5) begin n_bad++; $display("FAIL run_stop: got %0d want 5", phase); end
        n_cmp++; if (step_count !== 16'd33) begin n_bad++; $display("FAIL run_count: got %0d want 33", step_count); end
        n_cmp++; if ({fault, halted} !== 2'b10) begin n_bad++; $display("FAIL run_flags: got %b want 10", {fault, halted}); end
        n_cmp++; if (curr_state !== 3'd0) begin n_bad++; $display("FAIL run_state: got %0d want 0", curr_state); end
        n_cmp++; if (sat_count !== 4'hF) begin n_bad++; $display("FAIL sat_count: got %0h want f", sat_count); end
        n_cmp++; if ({sat_fault, sat_halted, sat_phase, sat_state, sat_ready} !== {1'b1, 1'b0, 3'd5, 3'd0, 1'b0}) begin
            n_bad++; $display("FAIL sat_misc: got %b want 1010100000", {sat_fault, sat_halted, sat_phase, sat_state, sat_ready});
        end
        @(negedge clock);
        n_cmp++; if (display_out !== 22'h000AAA) begin n_bad++; $display("FAIL run_disp: got %0h want aaa", display_out); end
        n_cmp++; if (sat_disp !== 22'h000AAA) begin n_bad++; $display("FAIL sat_disp: got %0h want aaa", sat_disp); end
        repeat (4) @(negedge clock);
        n_cmp++; if (step_count !== 16'd33) begin n_bad++; $display("FAIL fault_hold: got %0d want 33", step_count); end
        run_en = 1'b0;
    endtask

    task automatic test_pause_and_reset();
        do_reset();
        load_left_table();
        run_en = 1'b1;
        for (int i = 0; i < 20 && phase !== 3'd3; i++) @(negedge clock);
        run_en = 1'b0;                       // drop run while in FETCH
        repeat (2) @(negedge clock);
        n_cmp++; if (step_count !== 16'd1 || phase !== 3'd2) begin
            n_bad++; $display("FAIL pause_done: got count %0d phase %0d want 1 2", step_count, phase);
        end
        repeat (6) @(negedge clock);
        n_cmp++; if (step_count !== 16'd1 || phase !== 3'd2) begin
            n_bad++; $display("FAIL pause_wait: got count %0d phase %0d want 1 2", step_count, phase);
        end
        run_en = 1'b1;
        for (int i = 0; i < 20 && phase !== 3'd4; i++) @(negedge clock);
        n_cmp++; if (phase !== 3'd4) begin n_bad++; $display("FAIL mid_exec: got %0d want 4", phase); end
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1; run_en = 1'b0;
        n_cmp++; if (phase !== 3'd0 || prog_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_rst_phase: got phase %0d ready %0b want 0 1", phase, prog_ready);
        end
        n_cmp++; if (display_out !== 22'h0 || step_count !== 16'd0 || curr_state !== 3'd0) begin
            n_bad++; $display("FAIL mid_rst_vals: got disp %0h count %0d state %0d want 0 0 0", display_out, step_count, curr_state);
        end
        n_cmp++; if ({halted, fault} !== 2'b00) begin n_bad++; $display("FAIL mid_rst_flags: got %b want 00", {halted, fault}); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_single_step();
        test_step_drop();
        test_halt();
        test_run_fault();
        test_pause_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
